// File: rtl/i3c_data_frombus_sys_pkg.sv
// Shared types and constants for the I3C slave system-side receive FIFO.
// Holds the trigger-level codes, FSM state encoding and FIFO entry layout.
package i3c_data_frombus_sys_pkg;

    localparam logic [1:0] FB_TRIG_1    = 2'd0;
    localparam logic [1:0] FB_TRIG_QTR  = 2'd1;
    localparam logic [1:0] FB_TRIG_HALF = 2'd2;
    localparam logic [1:0] FB_TRIG_3QTR = 2'd3;

    typedef enum logic {
        FB_ST_ACCEPT  = 1'b0,
        FB_ST_DISCARD = 1'b1
    } fb_state_e;

    localparam int FB_ENTRY_W = 9;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } fb_entry_t;

    // Occupancy level that raises int_rx; the quarter level never drops below one entry.
    function automatic int fb_trig_thr(input logic [1:0] trig, input int depth);
        int thr;
        thr = 1;
        case (trig)
            FB_TRIG_1:    thr = 1;
            FB_TRIG_QTR:  thr = (depth / 4 < 1) ? 1 : depth / 4;
            FB_TRIG_HALF: thr = depth / 2;
            FB_TRIG_3QTR: thr = (3 * depth) / 4;
            default:      thr = 1;
        endcase
        return thr;
    endfunction

endpackage

// File: rtl/i3c_data_frombus_sys_fifo_mem.sv
// Register-array FIFO storage: one synchronous write port, one asynchronous read port,
// plus a dedicated port that forces the end bit of an existing entry to 1.
module i3c_fifo_mem_1w1r #(
    parameter int WIDTH = 9,
    parameter int BITS  = 3
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [BITS-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [BITS-1:0]  raddr,
    output logic [WIDTH-1:0] rdata,
    input  logic             tag_we,
    input  logic [BITS-1:0]  tag_addr,
    output logic             tag_rd
);

    localparam int DEPTH = 1 << BITS;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are intentionally not reset; the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (tag_we) begin
            mem_q[tag_addr][WIDTH-1] <= 1'b1;
        end
    end

    assign rdata  = mem_q[raddr];
    assign tag_rd = mem_q[tag_addr][WIDTH-1];

endmodule

// File: rtl/i3c_data_frombus_sys.sv
// System-side receive FIFO for I3C write data: stores {end,data} bytes from the SDR engine,
// serves them through a ready/ack handshake and tracks counts, trigger interrupt and overrun.
module i3c_data_frombus_sys
    import i3c_data_frombus_sys_pkg::*;
#(
    parameter int FIFO_BITS = 3,
    parameter bit ACK_COMB  = 1'b0
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       fb_valid,
    input  logic [7:0] fb_datab,
    input  logic       fb_end,
    input  logic       rx_flush,
    output logic       avail_fb_ready,
    output logic [7:0] avail_fb_data,
    output logic       avail_fb_end,
    input  logic       avail_fb_ack,
    output logic [4:0] avail_byte_cnt,
    output logic [4:0] avail_msg_cnt,
    input  logic [1:0] rx_trig,
    output logic       int_rx,
    output logic       set_fb_orun,
    input  logic       clear_fb_orun
);

    localparam int DEPTH = 1 << FIFO_BITS;
    localparam int CW    = FIFO_BITS + 1;

    logic [FIFO_BITS-1:0] wptr_q, wptr_d;
    logic [FIFO_BITS-1:0] rptr_q, rptr_d;
    logic [FIFO_BITS-1:0] wprev;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        msg_q, msg_d;
    logic [CW-1:0]        thr;
    fb_state_e            state_q, state_d;
    logic                 orun_q, orun_d;

    fb_entry_t head;
    logic      tail_last;
    logic      ready, full, pop, accepting, push_ok, overrun, retag;

    assign ready = (count_q != '0);
    assign full  = (count_q == CW'(DEPTH));

    // ready depends only on registers, so an external requester may drive ack
    // combinationally from it; the pop decode is the same in both modes.
    generate
        if (ACK_COMB) begin : g_ack_comb
            assign pop = ready & avail_fb_ack;
        end else begin : g_ack_reg
            assign pop = ready & avail_fb_ack;
        end
    endgenerate

    assign accepting = fb_valid & (state_q == FB_ST_ACCEPT) & ~rx_flush;
    assign push_ok   = accepting & (~full | pop);
    assign overrun   = accepting & full & ~pop;
    assign retag     = overrun & ~tail_last;
    assign wprev     = wptr_q - FIFO_BITS'(1);

    i3c_fifo_mem_1w1r #(
        .WIDTH (FB_ENTRY_W),
        .BITS  (FIFO_BITS)
    ) u_mem (
        .CLK      (CLK),
        .we       (push_ok),
        .waddr    (wptr_q),
        .wdata    ({fb_end, fb_datab}),
        .raddr    (rptr_q),
        .rdata    (head),
        .tag_we   (overrun),
        .tag_addr (wprev),
        .tag_rd   (tail_last)
    );

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        msg_d   = msg_q;
        state_d = state_q;
        if (rx_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            msg_d   = '0;
            state_d = FB_ST_ACCEPT;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + FIFO_BITS'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + FIFO_BITS'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            // An overrun closes the stored message early, so it counts as a new end tag.
            msg_d = msg_q + CW'(push_ok & fb_end) + CW'(retag) - CW'(pop & head.last);
            case (state_q)
                FB_ST_ACCEPT: begin
                    if (overrun && !fb_end) begin
                        state_d = FB_ST_DISCARD;
                    end
                end
                FB_ST_DISCARD: begin
                    if (fb_valid && fb_end) begin
                        state_d = FB_ST_ACCEPT;
                    end
                end
                default: state_d = FB_ST_ACCEPT;
            endcase
        end
        if (overrun) begin
            orun_d = 1'b1;
        end else if (clear_fb_orun) begin
            orun_d = 1'b0;
        end else begin
            orun_d = orun_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            msg_q   <= '0;
            state_q <= FB_ST_ACCEPT;
            orun_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            msg_q   <= msg_d;
            state_q <= state_d;
            orun_q  <= orun_d;
        end
    end

    assign thr = CW'(fb_trig_thr(rx_trig, DEPTH));

    // Head fields are gated so stale memory never shows while the FIFO is empty.
    assign avail_fb_ready = ready;
    assign avail_fb_data  = ready ? head.data : 8'h00;
    assign avail_fb_end   = ready & head.last;
    assign avail_byte_cnt = 5'(count_q);
    assign avail_msg_cnt  = 5'(msg_q);
    assign int_rx         = (count_q >= thr) | (msg_q != '0);
    assign set_fb_orun    = orun_q;

endmodule

// File: tb/tb_i3c_data_frombus_sys.sv
// Randomized self-checking bench for i3c_data_frombus_sys against a queue-based model.
// Directed sequences cover the fill/drain, overrun, trigger, flush and reset cases first.
module tb_i3c_data_frombus_sys;

    localparam int FB    = 3;
    localparam int DEPTH = 1 << FB;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       fb_valid;
    logic [7:0] fb_datab;
    logic       fb_end;
    logic       rx_flush;
    logic       avail_fb_ready;
    logic [7:0] avail_fb_data;
    logic       avail_fb_end;
    logic       avail_fb_ack;
    logic [4:0] avail_byte_cnt;
    logic [4:0] avail_msg_cnt;
    logic [1:0] rx_trig;
    logic       int_rx;
    logic       set_fb_orun;
    logic       clear_fb_orun;

    always #5 CLK = ~CLK;

    i3c_data_frombus_sys #(.FIFO_BITS(FB), .ACK_COMB(1'b0)) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .fb_valid       (fb_valid),
        .fb_datab       (fb_datab),
        .fb_end         (fb_end),
        .rx_flush       (rx_flush),
        .avail_fb_ready (avail_fb_ready),
        .avail_fb_data  (avail_fb_data),
        .avail_fb_end   (avail_fb_end),
        .avail_fb_ack   (avail_fb_ack),
        .avail_byte_cnt (avail_byte_cnt),
        .avail_msg_cnt  (avail_msg_cnt),
        .rx_trig        (rx_trig),
        .int_rx         (int_rx),
        .set_fb_orun    (set_fb_orun),
        .clear_fb_orun  (clear_fb_orun)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state: stored entries as {end,data}, sticky overrun, discarding-rest-of-message.
    logic [8:0] mq[$];
    bit         m_orun = 1'b0;
    bit         m_disc = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int thr_of(input int t);
        case (t)
            0:       return 1;
            1:       return (DEPTH / 4 < 1) ? 1 : DEPTH / 4;
            2:       return DEPTH / 2;
            default: return (3 * DEPTH) / 4;
        endcase
    endfunction

    task automatic check_outputs();
        int msgs;
        msgs = 0;
        foreach (mq[i]) if (mq[i][8]) msgs++;
        chk("ready", int'(avail_fb_ready), int'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("data", int'(avail_fb_data), int'(mq[0][7:0]));
            chk("end", int'(avail_fb_end), int'(mq[0][8]));
        end
        chk("byte_cnt", int'(avail_byte_cnt), mq.size());
        chk("msg_cnt", int'(avail_msg_cnt), msgs);
        chk("int_rx", int'(int_rx), int'((mq.size() >= thr_of(int'(rx_trig))) || (msgs != 0)));
        chk("orun", int'(set_fb_orun), int'(m_orun));
    endtask

    // Applies one clock edge worth of behaviour to the model using the driven inputs.
    task automatic model_edge();
        bit         pop;
        bit         full;
        bit         ovr;
        logic [8:0] t;
        if (!RSTn) begin
            mq.delete();
            m_orun = 1'b0;
            m_disc = 1'b0;
            return;
        end
        pop = (mq.size() != 0) && avail_fb_ack;
        ovr = 1'b0;
        if (rx_flush) begin
            mq.delete();
            m_disc = 1'b0;
        end else begin
            full = (mq.size() == DEPTH);
            if (pop) begin
                $display("pop data=%02h end=%0d", mq[0][7:0], mq[0][8]);
                void'(mq.pop_front());
            end
            if (fb_valid) begin
                if (m_disc) begin
                    if (fb_end) m_disc = 1'b0;
                end else if (!full || pop) begin
                    mq.push_back({fb_end, fb_datab});
                end else begin
                    ovr = 1'b1;
                    t = mq[mq.size() - 1];
                    t[8] = 1'b1;
                    mq[mq.size() - 1] = t;
                    m_disc = !fb_end;
                end
            end
        end
        if (ovr) m_orun = 1'b1;
        else if (clear_fb_orun) m_orun = 1'b0;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit e, input bit a,
                        input bit f, input bit c, input bit r);
        fb_valid      = v;
        fb_datab      = d;
        fb_end        = e;
        avail_fb_ack  = a;
        rx_flush      = f;
        clear_fb_orun = c;
        RSTn          = r;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_outputs();
    endtask

    initial begin
        int pv;
        int pa;
        RSTn = 1'b0;
        fb_valid = 1'b0;
        fb_datab = 8'h00;
        fb_end = 1'b0;
        rx_flush = 1'b0;
        avail_fb_ack = 1'b0;
        rx_trig = 2'd0;
        clear_fb_orun = 1'b0;
        @(negedge CLK);
        step(0, 8'h00, 0, 0, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0, 0, 0);
        chk("rst_data", int'(avail_fb_data), 0);
        chk("rst_int", int'(int_rx), 0);

        // Fill with one message, then full+pop, then overrun with retro-tag.
        for (int i = 0; i < 8; i++) step(1, 8'h11 + 8'(i), i == 7, 0, 0, 0, 1);
        chk("dir_cnt8", int'(avail_byte_cnt), 8);
        chk("dir_msg1", int'(avail_msg_cnt), 1);
        chk("dir_int", int'(int_rx), 1);
        step(1, 8'h19, 0, 1, 0, 0, 1);
        chk("dir_fullpop_cnt", int'(avail_byte_cnt), 8);
        chk("dir_fullpop_orun", int'(set_fb_orun), 0);
        for (int i = 0; i < 3; i++) step(1, 8'h20 + 8'(i), i == 2, 0, 0, 0, 1);
        chk("dir_orun", int'(set_fb_orun), 1);
        chk("dir_msg_retag", int'(avail_msg_cnt), 2);
        step(0, 8'h00, 0, 1, 0, 0, 1);
        step(1, 8'hAA, 0, 0, 0, 0, 1);
        chk("dir_aa_cnt", int'(avail_byte_cnt), 8);
        step(0, 8'h00, 0, 0, 0, 1, 1);
        chk("dir_clear", int'(set_fb_orun), 0);
        repeat (8) step(0, 8'h00, 0, 1, 0, 0, 1);

        // Flush with a colliding byte.
        for (int i = 0; i < 5; i++) step(1, 8'h40 + 8'(i), 0, 0, 0, 0, 1);
        step(1, 8'h55, 0, 0, 1, 0, 1);
        chk("dir_flush_cnt", int'(avail_byte_cnt), 0);
        chk("dir_flush_rdy", int'(avail_fb_ready), 0);

        // Half-depth trigger.
        rx_trig = 2'd2;
        for (int i = 0; i < 3; i++) step(1, 8'h60 + 8'(i), 0, 0, 0, 0, 1);
        chk("dir_trig3", int'(int_rx), 0);
        step(1, 8'h63, 0, 0, 0, 0, 1);
        chk("dir_trig4", int'(int_rx), 1);
        step(0, 8'h00, 0, 0, 1, 0, 1);

        // Reset while discarding the tail of an overrun message.
        for (int i = 0; i < 8; i++) step(1, 8'h70 + 8'(i), 0, 0, 0, 0, 1);
        step(1, 8'h7F, 0, 0, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0, 0, 0);
        chk("dir_rst_cnt", int'(avail_byte_cnt), 0);
        chk("dir_rst_orun", int'(set_fb_orun), 0);
        step(1, 8'h81, 0, 0, 0, 0, 1);
        chk("dir_rst_accept", int'(avail_byte_cnt), 1);

        for (int ph = 0; ph < 15; ph++) begin
            pv = $urandom_range(20, 95);
            pa = $urandom_range(5, 90);
            rx_trig = 2'($urandom_range(0, 3));
            for (int cyc = 0; cyc < 200; cyc++) begin
                step(($urandom % 100) < pv, 8'($urandom), ($urandom % 4) == 0,
                     ($urandom % 100) < pa, ($urandom % 100) == 0,
                     ($urandom % 30) == 0, ($urandom % 300) != 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
